// File: rtl/dram_resp_pkg.sv
// Shared configuration for the DRAM responder: data width and small helpers.
package dram_resp_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned XSTRB  = XLEN / 8;
    // Wait-state counter width; covers the full 0..15 wait-state range.
    localparam int unsigned WCNT_W = 4;

    // True when every address bit above the word-index field is zero.
    function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                           input int unsigned     idx_msb);
        return (addr >> (idx_msb + 1)) == '0;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port, byte-enabled, synchronous-read RAM with no reset.
module ram_sp #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Byte-masked write; read data register only updates on an enabled read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WIDTH / 8; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dram_resp.sv
// DRAM responder: wait-state FSM, address decode/range check and load-valid generation
// in front of a single-port backing RAM.
module dram_resp
    import dram_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             dram_req,
    input  logic             dram_write,
    input  logic [XSTRB-1:0] dram_wstrb,
    input  logic [XLEN-1:0]  dram_addr,
    input  logic [XLEN-1:0]  dram_wdata,
    output logic             dram_ready,
    output logic [XLEN-1:0]  dram_rdata,
    output logic             dram_rvalid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [WCNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic              rvalid_q;
    logic              rzero_q;
    logic              accept;
    logic              in_range;
    logic [AW-1:0]     word_idx;
    logic [XLEN-1:0]   ram_rdata;
    logic              unused_addr_bits;

    assign word_idx         = dram_addr[AW+1:2];
    assign in_range         = addr_in_range(dram_addr, AW + 1);
    assign unused_addr_bits = ^dram_addr[1:0];
    // Qualified by rst_b so nothing can commit while reset is held.
    assign accept           = dram_req & dram_ready & rst_b;

    // Next-state, wait counter and ready decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dram_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ZERO_WAIT) begin
                    dram_ready = dram_req;
                end else if (dram_req) begin
                    state_d = StWait;
                    cnt_d   = CNT_INIT;
                end
            end
            StWait: begin
                if (!dram_req) begin
                    // Initiator abandoned the request.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    dram_ready = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q - WCNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load-valid pulse and zero-data flag (reset and out-of-range loads read as 0).
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rvalid_q <= 1'b0;
            rzero_q  <= 1'b1;
        end else begin
            rvalid_q <= accept & ~dram_write;
            if (accept && !dram_write) begin
                rzero_q <= ~in_range;
            end
        end
    end

    assign dram_rvalid = rvalid_q;
    assign dram_rdata  = rzero_q ? '0 : ram_rdata;

    ram_sp #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (accept & in_range),
        .we    (dram_write),
        .be    (dram_wstrb),
        .addr  (word_idx),
        .wdata (dram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dram_resp.sv
// Directed bench: three responders (0, 2 and 3 wait states) sharing one stimulus bus.
module tb_dram_resp;
    import dram_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [2:0]  req;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [31:0] rd [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dram_resp #(.DEPTH(4096), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .dram_req(req[0]), .dram_write(wr), .dram_wstrb(strb),
        .dram_addr(addr), .dram_wdata(wdata), .dram_ready(rdy[0]), .dram_rdata(rd[0]),
        .dram_rvalid(rv[0])
    );

    dram_resp #(.DEPTH(4096), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst_b(rst_b), .dram_req(req[1]), .dram_write(wr), .dram_wstrb(strb),
        .dram_addr(addr), .dram_wdata(wdata), .dram_ready(rdy[1]), .dram_rdata(rd[1]),
        .dram_rvalid(rv[1])
    );

    dram_resp #(.DEPTH(4096), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_b(rst_b), .dram_req(req[2]), .dram_write(wr), .dram_wstrb(strb),
        .dram_addr(addr), .dram_wdata(wdata), .dram_ready(rdy[2]), .dram_rdata(rd[2]),
        .dram_rvalid(rv[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request on DUT sel (called at a negedge); count stall cycles, then check
    // stall count, rvalid and (for loads) rdata in the cycle after acceptance.
    task automatic do_req(input int sel, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int exp_stalls,
                          input logic [31:0] exp_rd, input string tag);
        int stalls = 0;
        bit got    = 1'b0;
        wr   = w;
        addr = a;
        wdata = d;
        strb = s;
        req[sel] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rdy[sel]) begin
                got = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (!got) check({tag, " ready timeout"}, 32'd0, 32'd1);
        check({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        @(negedge clk);
        req[sel] = 1'b0;
        check({tag, " rvalid"}, {31'd0, rv[sel]}, {31'd0, ~w});
        if (!w) check({tag, " rdata"}, rd[sel], exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0;
        req   = '0;
        wr    = 1'b0;
        strb  = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        check("reset rvalid", {29'd0, rv}, 32'd0);
        check("reset rdata ws0", rd[0], 32'd0);
        check("reset rdata ws3", rd[2], 32'd0);
        check("reset ready ws2/ws3", {30'd0, rdy[2:1]}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // Zero-wait store then load the next cycle (write-then-read ordering).
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, "ws0 store");
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF, "ws0 load");
        @(negedge clk);
        check("ws0 rvalid one cycle", {31'd0, rv[0]}, 32'd0);
        check("ws0 rdata hold", rd[0], 32'hDEADBEEF);

        // Byte and half-word strobes.
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, "strb init");
        do_req(0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'h2, 0, 32'h0, "strb byte1");
        do_req(0, 1'b1, 32'h20, 32'hBBBBBBBB, 4'hC, 0, 32'h0, "strb upper");
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'hBBBBAA44, "strb load");
        do_req(0, 1'b1, 32'h20, 32'h55555555, 4'hF, 0, 32'h0, "overwrite");
        check("rdata held over store", rd[0], 32'hBBBBAA44);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h55555555, "overwrite load");
        do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 32'h0, "zero strb store");
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h55555555, "zero strb load");

        // Out-of-range: 0x4000 aliases word 0 unless the range check drops it.
        do_req(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 0, 32'h0, "word0 init");
        do_req(0, 1'b1, 32'h4000, 32'hFFFFFFFF, 4'hF, 0, 32'h0, "oor store");
        do_req(0, 1'b0, 32'h4000, 32'h0, 4'hF, 0, 32'h0, "oor load");
        do_req(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, 32'h01020304, "word0 after oor");
        do_req(2, 1'b0, 32'h4000, 32'h0, 4'hF, 3, 32'h0, "ws3 oor load");

        // Three wait states, including back-to-back requests.
        do_req(2, 1'b1, 32'h40, 32'h12345678, 4'hF, 3, 32'h0, "ws3 store");
        do_req(2, 1'b0, 32'h40, 32'h0, 4'hF, 3, 32'h12345678, "ws3 load");
        do_req(2, 1'b0, 32'h40, 32'h0, 4'hF, 3, 32'h12345678, "ws3 b2b load");

        // Abandoned store on the two-wait-state responder.
        do_req(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 2, 32'h0, "ws2 store");
        wr = 1'b1;
        addr = 32'h30;
        wdata = 32'h0BAD0BAD;
        strb = 4'hF;
        req[1] = 1'b1;
        #1;
        check("abandon ready idle", {31'd0, rdy[1]}, 32'd0);
        @(negedge clk);
        #1;
        check("abandon ready wait", {31'd0, rdy[1]}, 32'd0);
        req[1] = 1'b0;
        @(negedge clk);
        check("abandon rvalid 0", {31'd0, rv[1]}, 32'd0);
        @(negedge clk);
        check("abandon rvalid 1", {31'd0, rv[1]}, 32'd0);
        do_req(1, 1'b0, 32'h30, 32'h0, 4'hF, 2, 32'hCAFEF00D, "ws2 load after abandon");

        // Reset asserted mid-WAIT of a store.
        do_req(2, 1'b1, 32'h50, 32'h600DCAFE, 4'hF, 3, 32'h0, "ws3 pre-rst store");
        do_req(2, 1'b0, 32'h50, 32'h0, 4'hF, 3, 32'h600DCAFE, "ws3 pre-rst load");
        wr = 1'b1;
        addr = 32'h50;
        wdata = 32'hDEADDEAD;
        strb = 4'hF;
        req[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("rst async rdata", rd[2], 32'h0);
        check("rst async rvalid", {31'd0, rv[2]}, 32'd0);
        check("rst ready", {31'd0, rdy[2]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst held ready", {31'd0, rdy[2]}, 32'd0);
        req[2] = 1'b0;
        rst_b = 1'b1;
        @(negedge clk);
        do_req(2, 1'b0, 32'h50, 32'h0, 4'hF, 3, 32'h600DCAFE, "ws3 load after rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_resp.md
DRAM_RESP -- requirements
Module: dram_resp

Interface
REQ-001 Parameter DEPTH, default 4096, number of 32-bit words in the backing store; power of two, minimum 4.
REQ-002 Parameter WAIT_STATES, default 1, cycles inserted between first sampled request and acceptance; legal range 0..15.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_b, input, 1, asynchronous active-low reset.
REQ-005 Port dram_req, input, 1, request valid; initiator holds it until accepted, or drops it on flush.
REQ-006 Port dram_write, input, 1, 1 = store, 0 = load.
REQ-007 Port dram_wstrb, input, XLEN/8, byte write enables, bit i covers wdata[8i+7:8i].
REQ-008 Port dram_addr, input, XLEN, byte address; word index = addr[log2(DEPTH)+1:2].
REQ-009 Port dram_wdata, input, XLEN, store data, already lane-replicated by initiator.
REQ-010 Port dram_ready, output, 1, request accepted this cycle; transfer occurs when req & ready.
REQ-011 Port dram_rdata, output, XLEN, full word of load data, not lane-shifted.
REQ-012 Port dram_rvalid, output, 1, one-cycle pulse marking dram_rdata valid for an accepted load.

Function
REQ-013 FSM states: IDLE, WAIT; WAIT is unreachable when WAIT_STATES = 0.
REQ-014 WAIT_STATES = 0: dram_ready = dram_req while in IDLE, combinationally, giving zero-wait acceptance.
REQ-015 WAIT_STATES > 0: IDLE & dram_req -> WAIT, with the wait counter loaded to WAIT_STATES-1; dram_ready = 0 in IDLE.
REQ-016 In WAIT, dram_ready = dram_req & (counter == 0); the counter decrements each cycle while nonzero and dram_req = 1.
REQ-017 Acceptance (req & ready) in WAIT returns the FSM to IDLE; a back-to-back request then incurs the full wait again.
REQ-018 Acceptance timing: for a request first sampled high at edge N, dram_ready is high in the cycle after edge N+WAIT_STATES-1, i.e. WAIT_STATES cycles of stall.
REQ-019 Abandon: dram_req = 0 while in WAIT -> IDLE next edge, counter cleared, no memory write, no rvalid.
REQ-020 Address, write, wstrb and wdata are sampled only in the acceptance cycle; earlier changes have no effect.
REQ-021 Store: at the acceptance edge, write the bytes with wstrb[i] = 1 into the addressed word; other bytes are unchanged; dram_rvalid stays 0.
REQ-022 Load: dram_rdata is registered from the addressed word at the acceptance edge and dram_rvalid = 1 for exactly the next cycle.
REQ-023 dram_rdata holds its value until the next accepted load, unaffected by stores, including stores to the same word.
REQ-024 A store accepted in cycle C followed by a load of the same word accepted in C+1 returns the new data (write-then-read ordering).
REQ-025 Out-of-range (addr[XLEN-1:log2(DEPTH)+2] != 0): store dropped; load returns 0 with the normal rvalid pulse; acceptance timing unchanged.
REQ-026 A store with wstrb = 0 is accepted normally and leaves memory unchanged.

Reset
REQ-027 While rst_b = 0, and asynchronously upon its assertion: FSM = IDLE, counter = 0, dram_rvalid = 0, dram_rdata = 0.
REQ-028 Reset asserted mid-WAIT or in an acceptance cycle cancels the transaction; no partial write commits after reset assertion.
REQ-029 Memory array contents are not reset and are undefined until written.
REQ-030 dram_ready is 0 during reset for WAIT_STATES > 0; for WAIT_STATES = 0 it follows dram_req, and the initiator keeps dram_req low in reset.

Structure
REQ-031 XLEN comes from the existing config header; no new shared constants are added there.
REQ-032 The FSM state typedef is local to dram_resp and not exported to the core package.
REQ-033 The storage is one sub-module, ram_sp: single-port, byte-enabled, synchronous read, DEPTH x XLEN, no reset.
REQ-034 dram_resp holds only the FSM, the counter, address decode/range check and rvalid generation.

Verification
REQ-035 WAIT_STATES=0: store 0xDEADBEEF, wstrb 0xF, to 0x10, then load 0x10 -> ready in the same cycle as each req; rdata 0xDEADBEEF with rvalid one cycle after the load accept.
REQ-036 WAIT_STATES=3: load held high -> ready asserts after exactly 3 stall cycles; rvalid in the following cycle; the next request waits 3 cycles again.
REQ-037 Byte/half strobes: word 0x11223344 at 0x20, store 0xAAAAAAAA with wstrb 0x2, then 0xBBBBBBBB with wstrb 0xC -> load returns 0xBBBBAA44.
REQ-038 Abandon: WAIT_STATES=2, store to 0x30 with req dropped after 1 cycle -> no ready, a later load of 0x30 returns the prior value, no rvalid for the dropped request.
REQ-039 Out-of-range: DEPTH=4096, store to 0x4000 -> dropped; load of 0x4000 -> rdata 0, rvalid 1; word 0x0 is unchanged.
REQ-040 Reset asserted mid-WAIT -> FSM IDLE and rvalid 0 immediately, target word unchanged; first request after release sees the full WAIT_STATES latency.
